// File: rtl/formula_2_pkg.sv
// Shared widths and types for the formula_2 pipeline.
package formula_2_pkg;

   localparam int WIDTH        = 32;
   localparam int ISQRT_STAGES = WIDTH / 2;

   typedef logic [WIDTH-1:0]   arg_t;
   typedef logic [WIDTH/2-1:0] root_t;

endpackage

// File: rtl/isqrt_pipe.sv
// Pipelined floor square root: restoring digit-by-digit, one root bit per stage, MSB first.
// Data registers load only on a valid token so y holds its last result across bubbles.
module isqrt_pipe
   import formula_2_pkg::*;
#(
   parameter int WIDTH = formula_2_pkg::WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x_vld,
   input  logic [WIDTH-1:0]   x,
   output logic               y_vld,
   output logic [WIDTH/2-1:0] y
);

   localparam int HW = WIDTH / 2;
   localparam int RW = HW + 2;

   logic             vld_q  [HW];
   logic [RW-1:0]    rem_q  [HW];
   logic [HW-1:0]    root_q [HW];
   logic [WIDTH-1:0] rad_q  [HW];

   for (genvar g = 0; g < HW; g++) begin : g_stage
      logic             vld_i;
      logic [RW-1:0]    rem_i;
      logic [HW-1:0]    root_i;
      logic [WIDTH-1:0] rad_i;
      logic [RW-1:0]    trial_rem;
      logic [RW-1:0]    trial_sub;
      logic             unused_rem_hi;

      if (g == 0) begin : g_head
         assign vld_i  = x_vld;
         assign rem_i  = '0;
         assign root_i = '0;
         assign rad_i  = x;
      end else begin : g_link
         assign vld_i  = vld_q[g-1];
         assign rem_i  = rem_q[g-1];
         assign root_i = root_q[g-1];
         assign rad_i  = rad_q[g-1];
      end

      // Incoming remainder never exceeds 2*root, so its top two bits are always zero.
      assign unused_rem_hi = ^rem_i[RW-1:RW-2];
      assign trial_rem     = {rem_i[RW-3:0], rad_i[WIDTH-1:WIDTH-2]};
      assign trial_sub     = {root_i, 2'b01};

      always_ff @(posedge clk) begin
         if (!rst) begin
            vld_q[g]  <= 1'b0;
            rem_q[g]  <= '0;
            root_q[g] <= '0;
            rad_q[g]  <= '0;
         end else begin
            vld_q[g] <= vld_i;
            if (vld_i) begin
               rad_q[g] <= rad_i << 2;
               if (trial_rem >= trial_sub) begin
                  rem_q[g]  <= trial_rem - trial_sub;
                  root_q[g] <= {root_i[HW-2:0], 1'b1};
               end else begin
                  rem_q[g]  <= trial_rem;
                  root_q[g] <= {root_i[HW-2:0], 1'b0};
               end
            end
         end
      end
   end

   logic unused_tail;
   assign unused_tail = ^{rem_q[HW-1], rad_q[HW-1]};

   assign y_vld = vld_q[HW-1];
   assign y     = root_q[HW-1];

endmodule

// File: rtl/formula_2_pipe.sv
// res = isqrt(a + isqrt(b + isqrt(c))), one argument set per clock, no backpressure.
// Define FORMULA_2_OUT_REG_EN to add a flop stage on res/res_vld (latency 49 instead of 48).
module formula_2_pipe
   import formula_2_pkg::*;
#(
   parameter int WIDTH        = formula_2_pkg::WIDTH,
   parameter int ISQRT_STAGES = formula_2_pkg::ISQRT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arg_vld,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             res_vld,
   output logic [WIDTH-1:0] res
);

   localparam int HW  = WIDTH / 2;
   localparam int ADL = 2 * ISQRT_STAGES;

   logic             s1_vld, s2_vld, s3_vld;
   logic [HW-1:0]    s1, s2, s3;
   logic             s2_in_vld, s3_in_vld;
   logic [WIDTH-1:0] s2_in, s3_in;

   logic [WIDTH-1:0] b_dly     [ISQRT_STAGES];
   logic             b_vld_dly [ISQRT_STAGES];
   logic [WIDTH-1:0] a_dly     [ADL];
   logic             a_vld_dly [ADL];

   // Operand delay lines: data shifts every cycle, valid tags travel alongside.
   for (genvar g = 0; g < ISQRT_STAGES; g++) begin : g_b_dly
      if (g == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (!rst) begin
               b_dly[g]     <= '0;
               b_vld_dly[g] <= 1'b0;
            end else begin
               b_dly[g]     <= b;
               b_vld_dly[g] <= arg_vld;
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk) begin
            if (!rst) begin
               b_dly[g]     <= '0;
               b_vld_dly[g] <= 1'b0;
            end else begin
               b_dly[g]     <= b_dly[g-1];
               b_vld_dly[g] <= b_vld_dly[g-1];
            end
         end
      end
   end

   for (genvar g = 0; g < ADL; g++) begin : g_a_dly
      if (g == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (!rst) begin
               a_dly[g]     <= '0;
               a_vld_dly[g] <= 1'b0;
            end else begin
               a_dly[g]     <= a;
               a_vld_dly[g] <= arg_vld;
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk) begin
            if (!rst) begin
               a_dly[g]     <= '0;
               a_vld_dly[g] <= 1'b0;
            end else begin
               a_dly[g]     <= a_dly[g-1];
               a_vld_dly[g] <= a_vld_dly[g-1];
            end
         end
      end
   end

   isqrt_pipe #(.WIDTH(WIDTH)) u_isqrt_c (
      .clk   (clk),
      .rst   (rst),
      .x_vld (arg_vld),
      .x     (c),
      .y_vld (s1_vld),
      .y     (s1)
   );

   // Sums wrap modulo 2^WIDTH; the carry is intentionally dropped.
   assign s2_in     = b_dly[ISQRT_STAGES-1] + {{(WIDTH-HW){1'b0}}, s1};
   assign s2_in_vld = s1_vld & b_vld_dly[ISQRT_STAGES-1];

   isqrt_pipe #(.WIDTH(WIDTH)) u_isqrt_b (
      .clk   (clk),
      .rst   (rst),
      .x_vld (s2_in_vld),
      .x     (s2_in),
      .y_vld (s2_vld),
      .y     (s2)
   );

   assign s3_in     = a_dly[ADL-1] + {{(WIDTH-HW){1'b0}}, s2};
   assign s3_in_vld = s2_vld & a_vld_dly[ADL-1];

   isqrt_pipe #(.WIDTH(WIDTH)) u_isqrt_a (
      .clk   (clk),
      .rst   (rst),
      .x_vld (s3_in_vld),
      .x     (s3_in),
      .y_vld (s3_vld),
      .y     (s3)
   );

`ifdef FORMULA_2_OUT_REG_EN
   logic             res_vld_q;
   logic [WIDTH-1:0] res_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         res_vld_q <= 1'b0;
         res_q     <= '0;
      end else begin
         res_vld_q <= s3_vld;
         if (s3_vld) begin
            res_q <= {{(WIDTH-HW){1'b0}}, s3};
         end
      end
   end

   assign res_vld = res_vld_q;
   assign res     = res_q;
`else
   assign res_vld = s3_vld;
   assign res     = {{(WIDTH-HW){1'b0}}, s3};
`endif

endmodule

// File: tb/tb_formula_2_pipe.sv
// Self-checking bench for formula_2_pipe against a plain-arithmetic reference of the formula.
module tb_formula_2_pipe;
   import formula_2_pkg::*;

`ifdef FORMULA_2_OUT_REG_EN
   localparam int LAT = 49;
`else
   localparam int LAT = 48;
`endif

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic arg_vld = 1'b0;
   arg_t a       = '0;
   arg_t b       = '0;
   arg_t c       = '0;
   logic res_vld;
   arg_t res;

   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   arg_t last_res = '0;

   always #5 clk = ~clk;

   formula_2_pipe dut (
      .clk     (clk),
      .rst     (rst),
      .arg_vld (arg_vld),
      .a       (a),
      .b       (b),
      .c       (c),
      .res_vld (res_vld),
      .res     (res)
   );

   function automatic arg_t isqrt_ref(arg_t x);
      longint unsigned x64, lo, hi, mid;
      x64 = {32'd0, x};
      lo  = 0;
      hi  = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= x64) lo = mid;
         else hi = mid - 1;
      end
      return arg_t'(lo);
   endfunction

   function automatic arg_t formula_ref(arg_t xa, arg_t xb, arg_t xc);
      arg_t t1, t2;
      t1 = xb + isqrt_ref(xc);
      t2 = xa + isqrt_ref(t1);
      return isqrt_ref(t2);
   endfunction

   function automatic arg_t rand_arg();
      int unsigned sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) return arg_t'($urandom_range(0, 300));
      if (sel == 1) return 32'hFFFF_FFFF - arg_t'($urandom_range(0, 70000));
      return arg_t'($urandom());
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive(input logic r, input logic v, input arg_t xa, input arg_t xb, input arg_t xc);
      rst     = r;
      arg_vld = v;
      a       = xa;
      b       = xb;
      c       = xc;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (res_vld !== 1'b0 || res !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got vld=%b res=%0d want vld=0 res=0", cyc, res_vld, res);
         end
         drive(1'b0, 1'b1, rand_arg(), rand_arg(), rand_arg());
      end
      for (int k = 0; k < 61; k++) begin
         tick();
         checks++;
         if (res_vld !== 1'b0 || res !== 32'd0) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got vld=%b res=%0d want vld=0 res=0", cyc, res_vld, res);
         end
         drive(1'b1, 1'b0, '0, '0, '0);
      end
      last_res = '0;
   endtask

   task automatic test_single(input string name, input arg_t xa, input arg_t xb, input arg_t xc,
                              input arg_t want);
      tick();
      drive(1'b1, 1'b1, xa, xb, xc);
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         drive(1'b1, 1'b0, '0, '0, '0);
         checks++;
         if (k == LAT) begin
            if (res_vld !== 1'b1 || res !== want) begin
               errors++;
               $display("FAIL %s_result k=%0d got vld=%b res=%0d want vld=1 res=%0d",
                        name, k, res_vld, res, want);
            end
         end else if (k < LAT) begin
            if (res_vld !== 1'b0 || res !== last_res) begin
               errors++;
               $display("FAIL %s_early k=%0d got vld=%b res=%0d want vld=0 res=%0d",
                        name, k, res_vld, res, last_res);
            end
         end else begin
            if (res_vld !== 1'b0 || res !== want) begin
               errors++;
               $display("FAIL %s_hold k=%0d got vld=%b res=%0d want vld=0 res=%0d",
                        name, k, res_vld, res, want);
            end
         end
      end
      last_res = want;
   endtask

   task automatic test_stream(input string name, input int n, input bit gaps);
      arg_t exp_q[int];
      int   sent    = 0;
      int   got     = 0;
      int   last_in = 0;
      for (int step = 0; step < 4 * n + LAT + 10; step++) begin
         logic v;
         arg_t xa, xb, xc;
         tick();
         checks++;
         if (exp_q.exists(cyc)) begin
            if (res_vld !== 1'b1 || res !== exp_q[cyc]) begin
               errors++;
               $display("FAIL %s_data cyc=%0d got vld=%b res=%0d want vld=1 res=%0d",
                        name, cyc, res_vld, res, exp_q[cyc]);
            end else begin
               got++;
            end
            last_res = exp_q[cyc];
            exp_q.delete(cyc);
         end else if (res_vld !== 1'b0 || res !== last_res) begin
            errors++;
            $display("FAIL %s_idle cyc=%0d got vld=%b res=%0d want vld=0 res=%0d",
                     name, cyc, res_vld, res, last_res);
         end
         if (sent < n) begin
            v  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            xa = rand_arg();
            xb = rand_arg();
            xc = rand_arg();
            if (v) begin
               exp_q[cyc + LAT] = formula_ref(xa, xb, xc);
               sent++;
               last_in = cyc;
            end
            drive(1'b1, v, xa, xb, xc);
         end else begin
            drive(1'b1, 1'b0, rand_arg(), rand_arg(), rand_arg());
            if (cyc > last_in + LAT + 1) break;
         end
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL %s_count got=%0d want=%0d", name, got, n);
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 1; k <= LAT + 20; k++) begin
         tick();
         checks++;
         if (k <= 20) begin
            if (res_vld !== 1'b0 || res !== last_res) begin
               errors++;
               $display("FAIL midrst_pre k=%0d got vld=%b res=%0d want vld=0 res=%0d",
                        k, res_vld, res, last_res);
            end
         end else if (res_vld !== 1'b0 || res !== 32'd0) begin
            errors++;
            $display("FAIL midrst_post k=%0d got vld=%b res=%0d want vld=0 res=0", k, res_vld, res);
         end
         if (k <= 10)       drive(1'b1, 1'b1, rand_arg(), rand_arg(), rand_arg());
         else if (k == 20)  drive(1'b0, 1'b1, rand_arg(), rand_arg(), rand_arg());
         else               drive(1'b1, 1'b0, '0, '0, '0);
      end
      last_res = '0;
   endtask

   initial begin
      test_reset();
      test_single("single", 32'd13, 32'd5, 32'd16, 32'd4);
      test_single("overflow", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15);
      test_stream("b2b", 200, 1'b0);
      test_stream("gaps", 200, 1'b1);
      test_mid_reset();
      test_single("zero", 32'd0, 32'd0, 32'd0, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/formula_2_pipe.md
Name: formula_2_pipe

Overview:
- Fully pipelined evaluator of res = isqrt(a + isqrt(b + isqrt(c))), where isqrt is the floor integer square root.
- Accepts one argument set per clock and has no backpressure.
- Sits between a valid-only producer and consumer in the formula homework datapath.
- Built from three cascaded pipelined isqrt units, plus delay lines that align a and b with the partial results.

Parameters:
- WIDTH, 32: bit width of a, b, c, the internal sums and res.
- ISQRT_STAGES, 16: pipeline stages per isqrt unit; must equal WIDTH/2, one result bit per stage.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- arg_vld  in  1  a, b, c are valid this cycle.
- a  in  WIDTH  outer operand.
- b  in  WIDTH  middle operand.
- c  in  WIDTH  innermost operand.
- res_vld  out  1  res is valid this cycle.
- res  out  WIDTH  result, zero-extended from WIDTH/2 bits.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst=0 at a clock edge):
  - All valid bits in every stage and delay line clear to 0; res_vld=0, res=0.
  - Data registers also clear to 0.
  - In-flight transactions are discarded; no res_vld pulse may follow for them.
  - arg_vld is ignored while rst=0.
- Stage 1: s1 = isqrt(c).
- Stage 2: s2 = isqrt(b_d + s1).
  - b_d is b delayed ISQRT_STAGES cycles.
  - The sum is unsigned modulo 2^WIDTH (carry dropped).
- Stage 3: res = isqrt(a_d + s2).
  - a_d is a delayed 2*ISQRT_STAGES cycles.
  - The sum is modulo 2^WIDTH.
- The adders are combinational in front of each isqrt input register.
- Latency: exactly 3*ISQRT_STAGES = 48 cycles from arg_vld to res_vld.
- Throughput: one result per cycle; back-to-back and bubbled inputs are both supported.
- Ordering: outputs come out in input order, one-to-one.
- Delay lines are valid-tagged shift registers. Data advances every cycle regardless of valid; valid bits reset to 0.
- res holds its last value when res_vld=0.
- isqrt unit:
  - Restoring digit-by-digit method, one result bit per stage, MSB first.
  - Each stage registers remainder, partial root, remaining radicand and valid.
  - Output is floor(sqrt(x)) for all x in [0, 2^WIDTH-1].

Optional Feature:
- FORMULA_2_OUT_REG_EN defined: an extra output register follows stage 3. res/res_vld latency is 49, and both outputs are driven directly from flops.
- Undefined: res/res_vld come from the last isqrt stage registers; latency is 48.

Decomposition:
- Package formula_2_pkg holds:
  - WIDTH and ISQRT_STAGES default constants;
  - typedef arg_t (logic [WIDTH-1:0]);
  - typedef root_t (logic [WIDTH/2-1:0]).
- One sub-module, isqrt_pipe (ports clk, rst, x_vld, x, y_vld, y), instantiated three times.
- Delay lines are inline generate loops in formula_2_pipe.

Test Plan:
- Reset: hold rst=0 for 3 cycles while arg_vld=1 -> res_vld=0 and res=0 throughout, and no res_vld for 60 cycles after release.
- Single transaction a=13, b=5, c=16 -> exactly 48 cycles later res_vld=1 with res=4 (isqrt 16=4, 5+4=9->3, 13+3=16->4).
- Overflow: a=b=c=0xFFFFFFFF -> res=15 (isqrt(c)=65535; b+65535 wraps to 65534 -> 255; a+255 wraps to 254 -> 15).
- Back-to-back streams:
  - Send 200 consecutive random triples -> 200 consecutive res_vld cycles, each matching the reference model in order.
  - Repeat with random arg_vld gaps -> gaps reproduced 48 cycles later.
- Mid-flight reset: send 10 triples, assert rst=0 for 1 cycle at cycle 20 -> none of the 10 results ever appear. Then a=0, b=0, c=0 -> res=0 after 48 cycles.
- Optional macro: with FORMULA_2_OUT_REG_EN defined, repeat the single-transaction case -> res=4 at exactly 49 cycles.
